// File: rtl/video_timing_pkg.sv
// Default 640x480@60 raster constants shared by the video timing generator files.
package video_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam bit HS_POL   = 1'b0;
  localparam bit VS_POL   = 1'b0;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int COORD_W  = 10;

endpackage

// File: rtl/video_timing_generator_if.sv
// Timing bundle between the generator (master) and the pixel stage (slave).
interface video_timing_generator_if;
  import video_timing_pkg::*;

  logic               i_en;
  logic               o_de;
  logic               o_hs;
  logic               o_vs;
  logic [COORD_W-1:0] o_x;
  logic [COORD_W-1:0] o_y;
  logic               o_line_start;
  logic               o_frame_start;

  modport master (
    input  i_en,
    output o_de, o_hs, o_vs, o_x, o_y, o_line_start, o_frame_start
  );

  modport slave (
    output i_en,
    input  o_de, o_hs, o_vs, o_x, o_y, o_line_start, o_frame_start
  );

endinterface

// File: rtl/video_timing_generator_wrap_counter.sv
// Modulo-MAX up counter; o_wrap flags the terminal count MAX-1.
module wrap_counter #(
  parameter int MAX = 800,
  parameter int W   = $clog2(MAX)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: wrap to zero after the terminal value
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register, advances only when incremented
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_inc) begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_wrap = (cnt_q == LAST);

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing generator: h/v counters, combinational decode, one output register stage.
module video_timing_generator #(
  parameter int H_ACTIVE = video_timing_pkg::H_ACTIVE,
  parameter int H_FP     = video_timing_pkg::H_FP,
  parameter int H_SYNC   = video_timing_pkg::H_SYNC,
  parameter int H_BP     = video_timing_pkg::H_BP,
  parameter int V_ACTIVE = video_timing_pkg::V_ACTIVE,
  parameter int V_FP     = video_timing_pkg::V_FP,
  parameter int V_SYNC   = video_timing_pkg::V_SYNC,
  parameter int V_BP     = video_timing_pkg::V_BP,
  parameter bit HS_POL   = video_timing_pkg::HS_POL,
  parameter bit VS_POL   = video_timing_pkg::VS_POL
) (
  input logic                      i_clk,
  input logic                      i_rst,
  video_timing_generator_if.master vt
);
  import video_timing_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_last_unused;

  wrap_counter #(.MAX(H_TOT), .W(HW)) u_h_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (vt.i_en),
    .o_cnt (h_cnt),
    .o_wrap(h_wrap)
  );

  wrap_counter #(.MAX(V_TOT), .W(VW)) u_v_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (vt.i_en & h_wrap),
    .o_cnt (v_cnt),
    .o_wrap(v_last_unused)
  );

  logic               de_d, hs_d, vs_d, ls_d, fs_d;
  logic               de_q, hs_q, vs_q, ls_q, fs_q;
  logic [COORD_W-1:0] x_d, y_d, x_q, y_q;

  // Decode the current counter position; vs follows v, which only moves at h wrap
  always_comb begin
    de_d = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    hs_d = ((int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC))
           ? HS_POL : ~HS_POL;
    vs_d = ((int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC))
           ? VS_POL : ~VS_POL;
    x_d  = de_d ? COORD_W'(h_cnt) : '0;
    y_d  = de_d ? COORD_W'(v_cnt) : '0;
    ls_d = (h_cnt == '0);
    fs_d = (h_cnt == '0) && (v_cnt == '0);
  end

  // Output register stage, frozen while disabled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      de_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      x_q  <= '0;
      y_q  <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else if (vt.i_en) begin
      de_q <= de_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      x_q  <= x_d;
      y_q  <= y_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign vt.o_de          = de_q;
  assign vt.o_hs          = hs_q;
  assign vt.o_vs          = vs_q;
  assign vt.o_x           = x_q;
  assign vt.o_y           = y_q;
  assign vt.o_line_start  = ls_q;
  assign vt.o_frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench: default 640x480 instance for line/enable/reset behaviour, a small
// instance (17x13 total, active-high hsync) for whole-frame behaviour.
module tb_video_timing_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  video_timing_generator_if vif_a ();
  video_timing_generator_if vif_b ();

  video_timing_generator dut_a (
    .i_clk(clk),
    .i_rst(rst),
    .vt   (vif_a.master)
  );

  video_timing_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_b (
    .i_clk(clk),
    .i_rst(rst),
    .vt   (vif_b.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags_a();
    return {vif_a.o_de, vif_a.o_hs, vif_a.o_vs, vif_a.o_line_start, vif_a.o_frame_start};
  endfunction

  function automatic logic [4:0] flags_b();
    return {vif_b.o_de, vif_b.o_hs, vif_b.o_vs, vif_b.o_line_start, vif_b.o_frame_start};
  endfunction

  initial begin
    int de_a = 0, de_bad_a = 0, hs_bad_a = 0, xy_bad_a = 0, ls_a = 0, ls_bad_a = 0;
    int fs_a = 0, vs_a = 0, hs0_cnt = 0, hs0_first = -1, hs0_last = -1, last_x0 = -1;
    int de_b = 0, de_bad_b = 0, hs_b = 0, hs_bad_b = 0, vs_b = 0, vs_bad_b = 0;
    int vs_chg_bad = 0, xy_bad_b = 0, ls_b = 0, ls_bad_b = 0, fs_b = 0, fs_bad_b = 0;
    int last_xb = -1, last_yb = -1;
    logic prev_vs_b;
    logic [4:0] frz;

    vif_a.i_en = 1'b0;
    vif_b.i_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_flags_a", flags_a(), 32'd12);   // de=0 hs=1 vs=1 ls=0 fs=0
    chk("rst_x_a", vif_a.o_x, 32'd0);
    chk("rst_y_a", vif_a.o_y, 32'd0);
    chk("rst_h_a", dut_a.h_cnt, 32'd0);
    chk("rst_v_a", dut_a.v_cnt, 32'd0);
    chk("rst_flags_b", flags_b(), 32'd4);    // de=0 hs=0 (active-high) vs=1

    rst = 1'b0;
    vif_a.i_en = 1'b1;
    vif_b.i_en = 1'b1;
    prev_vs_b = 1'b1;

    for (int n = 0; n < 8639; n++) begin
      int h, v, hb, vb;
      @(negedge clk);
      h = n % 800;
      v = n / 800;
      if (n == 0) begin
        chk("first_flags_a", flags_a(), 32'd31);
        chk("first_x_a", vif_a.o_x, 32'd0);
        chk("first_y_a", vif_a.o_y, 32'd0);
      end
      if (n == 1) begin
        chk("second_x_a", vif_a.o_x, 32'd1);
        chk("second_pulses_a", {vif_a.o_line_start, vif_a.o_frame_start}, 32'd0);
      end
      if (vif_a.o_de) de_a++;
      if (vif_a.o_de !== ((h < 640) && (v < 480))) de_bad_a++;
      if (vif_a.o_hs !== !((h >= 656) && (h < 752))) hs_bad_a++;
      if (vif_a.o_de && ((int'(vif_a.o_x) != h) || (int'(vif_a.o_y) != v))) xy_bad_a++;
      if (!vif_a.o_de && ((vif_a.o_x != 10'd0) || (vif_a.o_y != 10'd0))) xy_bad_a++;
      if (v == 0 && !vif_a.o_hs) begin
        hs0_cnt++;
        if (hs0_first < 0) hs0_first = h;
        hs0_last = h;
      end
      if (v == 0 && vif_a.o_de) last_x0 = int'(vif_a.o_x);
      if (vif_a.o_line_start) begin
        ls_a++;
        if (h != 0) ls_bad_a++;
      end
      if (vif_a.o_frame_start) fs_a++;
      if (!vif_a.o_vs) vs_a++;

      if (n < 442) begin
        hb = n % 17;
        vb = (n / 17) % 13;
        if (vif_b.o_de) de_b++;
        if (vif_b.o_de !== ((hb < 8) && (vb < 6))) de_bad_b++;
        if (vif_b.o_hs) hs_b++;
        if (vif_b.o_hs !== ((hb >= 10) && (hb < 13))) hs_bad_b++;
        if (!vif_b.o_vs) vs_b++;
        if (vif_b.o_vs !== !((vb >= 8) && (vb < 10))) vs_bad_b++;
        if ((vif_b.o_vs !== prev_vs_b) && (hb != 0)) vs_chg_bad++;
        prev_vs_b = vif_b.o_vs;
        if (vif_b.o_de && ((int'(vif_b.o_x) != hb) || (int'(vif_b.o_y) != vb))) xy_bad_b++;
        if (!vif_b.o_de && ((vif_b.o_x != 10'd0) || (vif_b.o_y != 10'd0))) xy_bad_b++;
        if (vif_b.o_line_start) begin
          ls_b++;
          if (hb != 0) ls_bad_b++;
        end
        if (vif_b.o_frame_start) begin
          fs_b++;
          if ((n % 221) != 0) fs_bad_b++;
        end
        if (n < 221 && vif_b.o_de) begin
          last_xb = int'(vif_b.o_x);
          last_yb = int'(vif_b.o_y);
        end
        if (n == 221) begin
          chk("wrap_flags_b", {vif_b.o_de, vif_b.o_frame_start}, 32'd3);
          chk("wrap_xy_b", {vif_b.o_x, vif_b.o_y}, 32'd0);
        end
      end
    end

    chk("de_count_a", de_a, 32'd7039);
    chk("de_decode_a", de_bad_a, 32'd0);
    chk("hs_decode_a", hs_bad_a, 32'd0);
    chk("xy_decode_a", xy_bad_a, 32'd0);
    chk("hs_line0_len", hs0_cnt, 32'd96);
    chk("hs_line0_first", hs0_first, 32'd656);
    chk("hs_line0_last", hs0_last, 32'd751);
    chk("line0_last_x", last_x0, 32'd639);
    chk("ls_count_a", ls_a, 32'd11);
    chk("ls_pos_a", ls_bad_a, 32'd0);
    chk("fs_count_a", fs_a, 32'd1);
    chk("vs_count_a", vs_a, 32'd0);

    chk("de_count_b", de_b, 32'd96);
    chk("de_decode_b", de_bad_b, 32'd0);
    chk("hs_count_b", hs_b, 32'd78);
    chk("hs_decode_b", hs_bad_b, 32'd0);
    chk("vs_count_b", vs_b, 32'd68);
    chk("vs_decode_b", vs_bad_b, 32'd0);
    chk("vs_edge_pos_b", vs_chg_bad, 32'd0);
    chk("xy_decode_b", xy_bad_b, 32'd0);
    chk("ls_count_b", ls_b, 32'd26);
    chk("ls_pos_b", ls_bad_b, 32'd0);
    chk("fs_count_b", fs_b, 32'd2);
    chk("fs_pos_b", fs_bad_b, 32'd0);
    chk("last_pix_x_b", last_xb, 32'd7);
    chk("last_pix_y_b", last_yb, 32'd5);

    // Freeze with counters at (639,10); outputs show (638,10)
    vif_a.i_en = 1'b0;
    frz = flags_a();
    chk("pre_freeze_x", vif_a.o_x, 32'd638);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("freeze_flags", flags_a(), 32'(frz));
      chk("freeze_xy", {vif_a.o_x, vif_a.o_y}, {12'd0, 10'd638, 10'd10});
      chk("freeze_h", dut_a.h_cnt, 32'd639);
    end
    vif_a.i_en = 1'b1;
    @(negedge clk);
    chk("resume_639_de", vif_a.o_de, 32'd1);
    chk("resume_639_xy", {vif_a.o_x, vif_a.o_y}, {12'd0, 10'd639, 10'd10});
    @(negedge clk);
    chk("resume_640_de", vif_a.o_de, 32'd0);
    chk("resume_640_xy", {vif_a.o_x, vif_a.o_y}, 32'd0);

    // Advance until counters sit at (300,11), then reset asynchronously mid-line
    repeat (459) @(negedge clk);
    chk("pre_rst_h", dut_a.h_cnt, 32'd300);
    chk("pre_rst_v", dut_a.v_cnt, 32'd11);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags_a", flags_a(), 32'd12);
    chk("async_rst_xy_a", {vif_a.o_x, vif_a.o_y}, 32'd0);
    chk("async_rst_h", dut_a.h_cnt, 32'd0);
    chk("async_rst_v", dut_a.v_cnt, 32'd0);
    chk("async_rst_flags_b", flags_b(), 32'd4);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_flags_a", flags_a(), 32'd31);
    chk("post_rst_xy_a", {vif_a.o_x, vif_a.o_y}, 32'd0);
    chk("post_rst_fs_b", vif_b.o_frame_start, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
